trap_ctrl: RTL

Machine-mode trap sequencer that drives the CSR file's write port and borrows its read port. It arbitrates between writeback CSR writes and its own trap/return sequences. On an exception, an enabled interrupt, or MRET, it stalls the pipeline and performs the CSR updates (mepc, mcause, mtval, mstatus) one write per cycle. It then reads mtvec or mepc and issues a one-cycle PC redirect to fetch.

---
 rtl/trap_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/return sequencer owning the CSR write port
module trap_ctrl #(
   parameter int XLEN      = 32,
   parameter bit VECTOR_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            exc_valid_i,
   input  logic [3:0]      exc_code_i,
   input  logic [XLEN-1:0] exc_pc_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic            irq_ext_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   input  logic [XLEN-1:0] int_pc_i,
   input  logic            mret_i,
   input  logic            wb_csr_we_i,
   input  logic [11:0]     wb_csr_waddr_i,
   input  logic [XLEN-1:0] wb_csr_wdata_i,
   input  logic [11:0]     id_csr_raddr_i,
   output logic            csr_we_o,
   output logic [11:0]     csr_waddr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   output logic [11:0]     csr_raddr_o,
   input  logic [XLEN-1:0] csr_rdata_i,
   output logic            stall_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);
   typedef enum logic [2:0] {
      IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_TVEC, RET, REDIR
   } state_t;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;
   localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

   state_t          state, state_nx;
   logic [XLEN-1:0] mstatus_sh, mie_sh;
   logic [XLEN-1:0] cause_q, pc_q, tval_q, target_q;
   logic            irq_q;
   logic            idle, irq_pend;
   logic [3:0]      irq_code;
   logic            accept_exc, accept_irq, accept_mret, accept;
   logic [XLEN-1:0] status_trap, status_ret, tvec_base, tvec_target;

   always_comb begin
      irq_code = 4'd7;
      if (irq_ext_i && mie_sh[11])
         irq_code = 4'd11;
      else if (irq_sw_i && mie_sh[3])
         irq_code = 4'd3;
   end

   assign irq_pend = mstatus_sh[3] & ((irq_ext_i & mie_sh[11]) |
                                      (irq_sw_i & mie_sh[3]) |
                                      (irq_timer_i & mie_sh[7]));

   assign idle        = (state == IDLE);
   assign accept_exc  = idle & exc_valid_i;
   assign accept_irq  = idle & ~exc_valid_i & irq_pend;
   assign accept_mret = idle & ~exc_valid_i & ~irq_pend & mret_i;
   assign accept      = accept_exc | accept_irq | accept_mret;

   always_comb begin
      status_trap        = mstatus_sh;
      status_trap[7]     = mstatus_sh[3];
      status_trap[3]     = 1'b0;
      status_trap[12:11] = 2'b11;
      status_ret         = mstatus_sh;
      status_ret[3]      = mstatus_sh[7];
      status_ret[7]      = 1'b1;
      status_ret[12:11]  = 2'b00;
   end

   // mtvec modes 2'b1x fall back to direct
   assign tvec_base   = csr_rdata_i & ALIGN;
   assign tvec_target = (VECTOR_EN && csr_rdata_i[1:0] == 2'b01 && irq_q)
                        ? tvec_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00}
                        : tvec_base;

   always_comb begin
      state_nx         = state;
      csr_we_o         = 1'b0;
      csr_waddr_o      = '0;
      csr_wdata_o      = '0;
      csr_raddr_o      = '0;
      stall_o          = 1'b1;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      case (state)
         IDLE: begin
            csr_we_o    = wb_csr_we_i;
            csr_waddr_o = wb_csr_waddr_i;
            csr_wdata_o = wb_csr_wdata_i;
            csr_raddr_o = id_csr_raddr_i;
            stall_o     = accept;
            if (accept_mret)
               state_nx = RET;
            else if (accept)
               state_nx = W_EPC;
         end
         W_EPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = A_MEPC;
            csr_wdata_o = pc_q & ALIGN;
            state_nx    = W_CAUSE;
         end
         W_CAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = A_MCAUSE;
            csr_wdata_o = cause_q;
            state_nx    = W_TVAL;
         end
         W_TVAL: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = A_MTVAL;
            csr_wdata_o = tval_q;
            state_nx    = W_STATUS;
         end
         W_STATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = A_MSTATUS;
            csr_wdata_o = status_trap;
            state_nx    = R_TVEC;
         end
         R_TVEC: begin
            csr_raddr_o = A_MTVEC;
            state_nx    = REDIR;
         end
         RET: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = A_MSTATUS;
            csr_wdata_o = status_ret;
            csr_raddr_o = A_MEPC;
            state_nx    = REDIR;
         end
         REDIR: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = target_q;
            state_nx         = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         mstatus_sh <= '0;
         mie_sh     <= '0;
         cause_q    <= '0;
         pc_q       <= '0;
         tval_q     <= '0;
         irq_q      <= 1'b0;
         target_q   <= '0;
      end else begin
         state <= state_nx;
         // snoop every write reaching the CSR file, ours included
         if (csr_we_o && csr_waddr_o == A_MSTATUS)
            mstatus_sh <= csr_wdata_o;
         if (csr_we_o && csr_waddr_o == A_MIE)
            mie_sh <= csr_wdata_o;
         if (accept_exc) begin
            cause_q <= {{(XLEN-4){1'b0}}, exc_code_i};
            pc_q    <= exc_pc_i;
            tval_q  <= exc_tval_i;
            irq_q   <= 1'b0;
         end else if (accept_irq) begin
            cause_q <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
            pc_q    <= int_pc_i;
            tval_q  <= '0;
            irq_q   <= 1'b1;
         end
         if (state == R_TVEC)
            target_q <= tvec_target;
         else if (state == RET)
            target_q <= csr_rdata_i & ALIGN;
      end
   end
endmodule
